// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one multiplier among NREQ requesters.
// Define MULT_ARBITER_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles.
module mult_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [16*NREQ-1:0]        req_x,
  input  logic [16*NREQ-1:0]        req_y,
  output logic                      mul_start,
  output logic [15:0]               mul_x,
  output logic [15:0]               mul_y,
  input  logic                      mul_done,
  input  logic [31:0]               mul_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [31:0]               rsp_prod,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int unsigned IdW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [15:0]      mul_x_q, mul_x_d, mul_y_q, mul_y_d;
  logic [IdW-1:0]   rsp_id_q, rsp_id_d;
  logic [31:0]      rsp_prod_q, rsp_prod_d;
  logic             grant_found;
  logic [IdW-1:0]   grant_idx;
  logic [IdW-1:0]   cand;
  logic             accept;

`ifdef MULT_ARBITER_TIMEOUT_EN
  logic [7:0]       cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  // Search ptr, ptr+1, ... so the most recent winner has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IdW'((32'(ptr_q) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign accept = (state_q == StIdle) && grant_found && !reset;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mul_x_d    = mul_x_q;
    mul_y_d    = mul_y_q;
    rsp_id_d   = rsp_id_q;
    rsp_prod_d = rsp_prod_q;
`ifdef MULT_ARBITER_TIMEOUT_EN
    cnt_d      = '0;
    rsp_err_d  = rsp_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StIssue;
          mul_x_d  = req_x[16*32'(grant_idx) +: 16];
          mul_y_d  = req_y[16*32'(grant_idx) +: 16];
          rsp_id_d = grant_idx;
          ptr_d    = IdW'((32'(grant_idx) + 1) % NREQ);
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        // A completion on the final allowed cycle beats the timeout.
        if (mul_done) begin
          state_d    = StResp;
          rsp_prod_d = mul_out;
`ifdef MULT_ARBITER_TIMEOUT_EN
          rsp_err_d  = 1'b0;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d    = StResp;
          rsp_prod_d = '0;
          rsp_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      mul_x_q    <= '0;
      mul_y_q    <= '0;
      rsp_id_q   <= '0;
      rsp_prod_q <= '0;
`ifdef MULT_ARBITER_TIMEOUT_EN
      cnt_q      <= '0;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mul_x_q    <= mul_x_d;
      mul_y_q    <= mul_y_d;
      rsp_id_q   <= rsp_id_d;
      rsp_prod_q <= rsp_prod_d;
`ifdef MULT_ARBITER_TIMEOUT_EN
      cnt_q      <= cnt_d;
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

  // State-decoded strobes are forced low while reset is held.
  assign mul_start = (state_q == StIssue) && !reset;
  assign rsp_valid = (state_q == StResp) && !reset;
  assign busy      = (state_q != StIdle) && !reset;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_prod  = rsp_prod_q;
`ifdef MULT_ARBITER_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural multiplier of programmable latency.
module tb_mult_arbiter;

  localparam int unsigned NREQ = 4;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [16*NREQ-1:0]    req_x;
  logic [16*NREQ-1:0]    req_y;
  logic                  mul_start;
  logic [15:0]           mul_x;
  logic [15:0]           mul_y;
  logic                  mul_done;
  logic [31:0]           mul_out;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [31:0]           rsp_prod;
  logic                  rsp_err;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  // Multiplier model controls
  logic mdl_en = 1'b1;
  int   mdl_delay = 1;
  int   start_cnt = 0;

  mult_arbiter #(.NREQ(NREQ), .TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .mul_start (mul_start),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_done  (mul_done),
    .mul_out   (mul_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Done pulses mdl_delay cycles after the start pulse; mul_out is junk otherwise.
  initial begin : mult_model
    logic signed [15:0] px, py;
    mul_done = 1'b0;
    mul_out  = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (mul_start === 1'b1) begin
        start_cnt++;
        if (mdl_en) begin
          px = mul_x;
          py = mul_y;
          repeat (mdl_delay) @(negedge clk);
          mul_done = 1'b1;
          mul_out  = 32'(px * py);
          @(negedge clk);
          mul_done = 1'b0;
          mul_out  = 32'hDEAD_BEEF;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 60) begin
      step();
      n++;
    end
  endtask

  initial begin : stim
    int n;
    int base;
    int id;

    reset     = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_x[16*i +: 16] = 16'(i + 1);
      req_y[16*i +: 16] = 16'd10;
    end
    mdl_delay = 1;
    step();
    step();

    // Reset state, with every requester already asserting valid
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mul_start", 32'(mul_start), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_mul_x", 32'(mul_x), 0);
    chk("rst_mul_y", 32'(mul_y), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_prod", rsp_prod, 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);

    // Round-robin with all requesters valid: 0,1,2,3,0
    reset = 1'b0;
    #1;
    base = start_cnt;
    for (int k = 0; k < 5; k++) begin
      id = k % 4;
      chk("rr_ready_onehot", 32'(req_ready), 32'(1) << id);
      step();
      chk("rr_mul_start", 32'(mul_start), 1);
      chk("rr_ready_busy", 32'(req_ready), 0);
      chk("rr_mul_x", 32'(mul_x), 32'(id + 1));
      wait_rsp(n);
      chk("rr_lat", 32'(n), 2);
      chk("rr_rsp_id", 32'(rsp_id), 32'(id));
      chk("rr_rsp_prod", rsp_prod, 32'(10 * (id + 1)));
      step();
    end
    chk("rr_starts", 32'(start_cnt - base), 5);
    req_valid = '0;

    // 3 * 5 on requester 0, done 9 cycles after start, then response held off
    req_x[15:0] = 16'd3;
    req_y[15:0] = 16'd5;
    mdl_delay   = 9;
    rsp_ready   = 1'b0;
    req_valid   = 4'b0001;
    #1;
    chk("b_ready", 32'(req_ready), 32'h1);
    base = start_cnt;
    step();
    req_valid = 4'hF;
    wait_rsp(n);
    chk("b_lat", 32'(n), 10);
    chk("b_rsp_id", 32'(rsp_id), 0);
    chk("b_rsp_prod", rsp_prod, 32'd15);
    chk("b_rsp_err", 32'(rsp_err), 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_id", 32'(rsp_id), 0);
      chk("hold_prod", rsp_prod, 32'd15);
      chk("hold_ready", 32'(req_ready), 0);
      chk("hold_start", 32'(mul_start), 0);
    end
    chk("b_starts", 32'(start_cnt - base), 1);
    rsp_ready = 1'b1;
    req_valid = '0;
    step();
    chk("b_release", {30'd0, rsp_valid, busy}, 0);

    // -2 * 7 on requester 2
    req_x[47:32] = 16'hFFFE;
    req_y[47:32] = 16'd7;
    mdl_delay    = 3;
    req_valid    = 4'b0100;
    step();
    req_valid = '0;
    wait_rsp(n);
    chk("c_lat", 32'(n), 4);
    chk("c_rsp_id", 32'(rsp_id), 2);
    chk("c_rsp_prod", rsp_prod, 32'hFFFF_FFF2);
    step();

    // Reset while waiting on requester 1; the late done must be ignored
    mdl_delay = 5;
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    chk("d_busy_wait", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("d_busy_in_rst", 32'(busy), 0);
    step();
    chk("d_mul_x", 32'(mul_x), 0);
    chk("d_mul_y", 32'(mul_y), 0);
    chk("d_rsp_id", 32'(rsp_id), 0);
    chk("d_rsp_prod", rsp_prod, 0);
    chk("d_rsp_err", 32'(rsp_err), 0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("d_idle", {29'd0, rsp_valid, busy, mul_start}, 0);
    end
    req_valid = 4'hF;
    #1;
    chk("d_ptr_zero", 32'(req_ready), 32'h1);
    req_valid = '0;
    #1;

`ifdef MULT_ARBITER_TIMEOUT_EN
    // No done: abort after 15 WAIT cycles
    mdl_en    = 1'b0;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    wait_rsp(n);
    chk("e_lat", 32'(n), 16);
    chk("e_rsp_err", 32'(rsp_err), 1);
    chk("e_rsp_prod", rsp_prod, 0);
    step();
    // Done on the 15th WAIT cycle wins over the timeout
    mdl_en    = 1'b1;
    mdl_delay = 15;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    wait_rsp(n);
    chk("e2_lat", 32'(n), 16);
    chk("e2_rsp_err", 32'(rsp_err), 0);
    chk("e2_rsp_prod", rsp_prod, 32'd15);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter: NREQ, 4, number of requesters (2..8).
REQ-002 SHALL have parameter: TIMEOUT, 15, max cycles in WAIT before abort (1..255).
REQ-003 SHALL have port: clk  in  1  clock, all logic on rising edge.
REQ-004 SHALL have port: reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: req_valid  in  NREQ  per-requester request valid; req_ready  out  NREQ  per-requester accept.
REQ-006 SHALL have ports: req_x, req_y  in  16*NREQ  signed operands, requester i in bits [16i+15:16i].
REQ-007 SHALL have ports: mul_start  out  1  one-cycle start pulse to the shared multiplier; mul_x, mul_y  out  16  operands to multiplier.
REQ-008 SHALL have ports: mul_done  in  1  multiplier completion; mul_out  in  32  signed product.
REQ-009 SHALL have ports: rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  clog2(NREQ)  granted requester index; rsp_prod  out  32  product; rsp_err  out  1  timeout flag.
REQ-010 SHALL have port: busy  out  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT, RESP; IDLE -> ISSUE on accept, ISSUE -> WAIT unconditionally, WAIT -> RESP on mul_done (or timeout), RESP -> IDLE on rsp_valid && rsp_ready.
REQ-012 SHALL arbitrate round-robin: in IDLE, grant the first i with req_valid[i] searching ptr, ptr+1, ... mod NREQ.
REQ-013 SHALL drive req_ready combinationally: one-hot at granted index only in IDLE with some req_valid high; all zero otherwise.
REQ-014 SHALL, on accept edge, latch granted req_x/req_y into mul_x/mul_y, latch index into rsp_id, and set ptr = (grant+1) mod NREQ.
REQ-015 SHALL hold mul_x/mul_y stable from accept until leaving WAIT.
REQ-016 SHALL assert mul_start for exactly the one cycle in ISSUE.
REQ-017 SHALL ignore mul_done outside WAIT; mul_done in WAIT latches mul_out into rsp_prod, rsp_err=0.
REQ-018 SHALL hold rsp_valid high in RESP, with rsp_id/rsp_prod/rsp_err stable until accepted; no new grant while in RESP.
REQ-019 SHALL pass mul_out unmodified (no sign or width conversion).
REQ-020 SHALL give min latency accept -> rsp_valid = 2 cycles + multiplier latency.
REQ-021 SHALL, with requesters dropping req_valid before accept, grant nothing; no requester starvation beyond NREQ-1 intervening grants.

Reset
REQ-022 SHALL on reset force state IDLE, ptr=0, timeout counter=0.
REQ-023 SHALL on reset drive mul_start=0, mul_x=0, mul_y=0, rsp_valid=0, rsp_id=0, rsp_prod=0, rsp_err=0, busy=0, req_ready=0 during reset cycle.
REQ-024 SHALL on reset mid-operation abandon the transaction; a later mul_done SHALL be ignored (state IDLE).

Configuration
REQ-025 SHALL use macro MULT_ARBITER_TIMEOUT_EN.
REQ-026 SHALL with macro defined: count cycles in WAIT; when count reaches TIMEOUT without mul_done, go RESP with rsp_prod=0, rsp_err=1; mul_done on the same cycle wins (normal result).
REQ-027 SHALL with macro undefined: wait indefinitely in WAIT; rsp_err tied 0; no counter logic.

Verification
REQ-028 SHALL cover: req_valid[0], x=3, y=5, model done 9 cycles after start -> rsp_id=0, rsp_prod=15, rsp_err=0, one mul_start pulse.
REQ-029 SHALL cover: x=-2 (0xFFFE), y=7 on requester 2 -> rsp_prod=0xFFFFFFF2, rsp_id=2.
REQ-030 SHALL cover: all four req_valid held high from reset -> grants/responses in order 0,1,2,3,0; req_ready one-hot only in IDLE.
REQ-031 SHALL cover: rsp_ready low 5 cycles in RESP -> rsp_valid, rsp_id, rsp_prod stable, req_ready all 0, no mul_start.
REQ-032 SHALL cover: reset asserted in WAIT, mul_done 2 cycles later -> all outputs 0, no rsp_valid, ptr=0.
REQ-033 SHALL cover (macro defined, TIMEOUT=15): mul_done never asserted -> rsp_valid after 15 WAIT cycles, rsp_err=1, rsp_prod=0; mul_done exactly on cycle 15 -> rsp_err=0.
